// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I sequencer (fetch, decode, execute, memory, writeback).
// Define PERF_COUNTERS_EN to build the instr_retired / stall_cycles counters.
module control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        br_en,
    input  logic [1:0]  mar_lo,
    input  logic        mem_resp,
    output logic        load_pc,
    output logic        load_ir,
    output logic        load_regfile,
    output logic        load_mar,
    output logic        load_mdr,
    output logic        load_data_out,
    output logic [1:0]  pcmux_sel,
    output logic        alumux1_sel,
    output logic [2:0]  alumux2_sel,
    output logic        cmpmux_sel,
    output logic        marmux_sel,
    output logic [2:0]  regfilemux_sel,
    output logic [2:0]  aluop,
    output logic [2:0]  cmpop,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic        illegal,
    output logic [31:0] instr_retired,
    output logic [31:0] stall_cycles
);
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6f;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_REG   = 7'h33;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SRA = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_SB   = 3'd0;
    localparam logic [2:0] F3_SH   = 3'd1;

    localparam logic [2:0] CMP_BLT  = 3'd4;
    localparam logic [2:0] CMP_BLTU = 3'd6;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC,
        BR, JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2
    } state_t;

    state_t state_reg, state_next;

    // Only funct7[5] distinguishes instructions in RV32I base.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= FETCH1;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next      = state_reg;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        pcmux_sel       = 2'd0;
        alumux1_sel     = 1'b0;
        alumux2_sel     = 3'd0;
        cmpmux_sel      = 1'b0;
        marmux_sel      = 1'b0;
        regfilemux_sel  = 3'd0;
        aluop           = ALU_ADD;
        cmpop           = 3'd0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'b1111;
        illegal         = 1'b0;
        // Outputs are held at their idle values for as long as reset is high.
        if (!rst) begin
            case (state_reg)
                FETCH1: begin
                    load_mar   = 1'b1;
                    state_next = FETCH2;
                end
                FETCH2: begin
                    mem_read = 1'b1;
                    load_mdr = mem_resp;
                    if (mem_resp) state_next = FETCH3;
                end
                FETCH3: begin
                    load_ir    = 1'b1;
                    state_next = DECODE;
                end
                DECODE: begin
                    case (opcode)
                        OP_IMM:             state_next = IMM;
                        OP_REG:             state_next = REG;
                        OP_LUI:             state_next = LUI;
                        OP_AUIPC:           state_next = AUIPC;
                        OP_BR:              state_next = BR;
                        OP_JAL:             state_next = JAL;
                        OP_JALR:            state_next = JALR;
                        OP_LOAD, OP_STORE:  state_next = CALC_ADDR;
                        default: begin
                            illegal    = 1'b1;
                            load_pc    = 1'b1;
                            state_next = FETCH1;
                        end
                    endcase
                end
                IMM, REG: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    state_next   = FETCH1;
                    if (state_reg == REG) alumux2_sel = 3'd5;
                    if (funct3 == F3_SLT || funct3 == F3_SLTU) begin
                        regfilemux_sel = 3'd1;
                        cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
                        cmpmux_sel     = (state_reg == IMM);
                    end else if (funct3 == F3_SR && funct7[5]) begin
                        aluop = ALU_SRA;
                    end else if (state_reg == REG && funct3 == F3_ADD && funct7[5]) begin
                        aluop = ALU_SUB;
                    end else begin
                        aluop = funct3;
                    end
                end
                LUI: begin
                    regfilemux_sel = 3'd2;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_next     = FETCH1;
                end
                AUIPC: begin
                    alumux1_sel  = 1'b1;
                    alumux2_sel  = 3'd1;
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    state_next   = FETCH1;
                end
                BR: begin
                    cmpop       = funct3;
                    alumux1_sel = 1'b1;
                    alumux2_sel = 3'd2;
                    load_pc     = 1'b1;
                    pcmux_sel   = {1'b0, br_en};
                    state_next  = FETCH1;
                end
                JAL: begin
                    regfilemux_sel = 3'd4;
                    load_regfile   = 1'b1;
                    alumux1_sel    = 1'b1;
                    alumux2_sel    = 3'd4;
                    pcmux_sel      = 2'd1;
                    load_pc        = 1'b1;
                    state_next     = FETCH1;
                end
                JALR: begin
                    regfilemux_sel = 3'd4;
                    load_regfile   = 1'b1;
                    pcmux_sel      = 2'd2;
                    load_pc        = 1'b1;
                    state_next     = FETCH1;
                end
                CALC_ADDR: begin
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    if (opcode == OP_STORE) begin
                        alumux2_sel   = 3'd3;
                        load_data_out = 1'b1;
                        state_next    = ST1;
                    end else begin
                        state_next = LD1;
                    end
                end
                LD1: begin
                    mem_read = 1'b1;
                    load_mdr = mem_resp;
                    if (mem_resp) state_next = LD2;
                end
                LD2: begin
                    regfilemux_sel = 3'd3;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_next     = FETCH1;
                end
                ST1: begin
                    mem_write = 1'b1;
                    case (funct3)
                        F3_SB:   mem_byte_enable = 4'b0001 << mar_lo;
                        F3_SH:   mem_byte_enable = 4'b0011 << {mar_lo[1], 1'b0};
                        default: mem_byte_enable = 4'b1111;
                    endcase
                    if (mem_resp) state_next = ST2;
                end
                ST2: begin
                    load_pc    = 1'b1;
                    state_next = FETCH1;
                end
                default: state_next = FETCH1;
            endcase
        end
    end

`ifdef PERF_COUNTERS_EN
    logic [31:0] retired_reg;
    logic [31:0] stall_reg;
    logic        waiting;

    assign waiting = (state_reg == FETCH2) || (state_reg == LD1) || (state_reg == ST1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_reg <= 32'd0;
            stall_reg   <= 32'd0;
        end else begin
            // FETCH1 never loops on itself, so any entry into it ends an instruction.
            if (state_next == FETCH1 && state_reg != FETCH1) retired_reg <= retired_reg + 32'd1;
            if (waiting && !mem_resp) stall_reg <= stall_reg + 32'd1;
        end
    end

    assign instr_retired = retired_reg;
    assign stall_cycles  = stall_reg;
`else
    assign instr_retired = 32'd0;
    assign stall_cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction expected output schedules built from the
// sequencing rules, compared against the DUT on every cycle, plus literal pins.
module tb_control_fsm;
`ifdef PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        br_en;
    logic [1:0]  mar_lo;
    logic        mem_resp;
    logic        load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic [1:0]  pcmux_sel;
    logic        alumux1_sel;
    logic [2:0]  alumux2_sel;
    logic        cmpmux_sel, marmux_sel;
    logic [2:0]  regfilemux_sel, aluop, cmpop;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_enable;
    logic        illegal;
    logic [31:0] instr_retired, stall_cycles;

    control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .mar_lo(mar_lo), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
        .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
        .cmpmux_sel(cmpmux_sel), .marmux_sel(marmux_sel), .regfilemux_sel(regfilemux_sel),
        .aluop(aluop), .cmpop(cmpop), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .illegal(illegal),
        .instr_retired(instr_retired), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ld_pc, ld_ir, ld_rf, ld_mar, ld_mdr, ld_dout;
        logic [1:0] pcmux;
        logic       amux1;
        logic [2:0] amux2;
        logic       cmux, mmux;
        logic [2:0] rfmux, alu, cmp;
        logic       rd, wr;
        logic [3:0] mbe;
        logic       ill;
    } outs_t;

    typedef struct packed {
        logic  resp;
        outs_t o;
    } step_t;

    step_t trace[$];
    outs_t seen[$];
    int    total = 0;
    int    passed = 0;
    int    exp_ret = 0;
    int    exp_stall = 0;
    int    last_len = 0;
    int    stall_add = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic outs_t cur();
        outs_t o;
        o.ld_pc = load_pc;       o.ld_ir = load_ir;        o.ld_rf = load_regfile;
        o.ld_mar = load_mar;     o.ld_mdr = load_mdr;      o.ld_dout = load_data_out;
        o.pcmux = pcmux_sel;     o.amux1 = alumux1_sel;    o.amux2 = alumux2_sel;
        o.cmux = cmpmux_sel;     o.mmux = marmux_sel;      o.rfmux = regfilemux_sel;
        o.alu = aluop;           o.cmp = cmpop;            o.rd = mem_read;
        o.wr = mem_write;        o.mbe = mem_byte_enable;  o.ill = illegal;
        return o;
    endfunction

    function automatic outs_t base();
        outs_t o;
        o = '0;
        o.mbe = 4'hF;
        return o;
    endfunction

    function automatic void push(input logic r, input outs_t o);
        step_t s;
        s.resp = r;
        s.o = o;
        trace.push_back(s);
    endfunction

    // Expected cycle-by-cycle schedule for one instruction; fd/md = memory wait cycles.
    function automatic void build(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic br, input logic [1:0] lo, input int fd, input int md);
        outs_t o;
        logic [3:0] mask;
        stall_add = fd - 1;
        o = base(); o.ld_mar = 1; push(1'b0, o);
        for (int i = 0; i < fd; i++) begin
            o = base(); o.rd = 1; o.ld_mdr = (i == fd - 1); push(i == fd - 1, o);
        end
        o = base(); o.ld_ir = 1; push(1'b0, o);
        o = base();
        case (opc)
            7'h13, 7'h33, 7'h37, 7'h17, 7'h63, 7'h6f, 7'h67, 7'h03, 7'h23: push(1'b0, o);
            default: begin o.ill = 1; o.ld_pc = 1; push(1'b0, o); return; end
        endcase
        o = base();
        case (opc)
            7'h13, 7'h33: begin
                o.ld_rf = 1; o.ld_pc = 1;
                if (opc == 7'h33) o.amux2 = 5;
                if (f3 == 2 || f3 == 3) begin
                    o.rfmux = 1;
                    o.cmp = (f3 == 2) ? 3'd4 : 3'd6;
                    o.cmux = (opc == 7'h13);
                end else begin
                    o.alu = f3;
                    if (f3 == 5 && f7[5]) o.alu = 3'd2;
                    if (opc == 7'h33 && f3 == 0 && f7[5]) o.alu = 3'd3;
                end
                push(1'b0, o);
            end
            7'h37: begin o.rfmux = 2; o.ld_rf = 1; o.ld_pc = 1; push(1'b0, o); end
            7'h17: begin o.amux1 = 1; o.amux2 = 1; o.ld_rf = 1; o.ld_pc = 1; push(1'b0, o); end
            7'h63: begin
                o.cmp = f3; o.amux1 = 1; o.amux2 = 2; o.ld_pc = 1; o.pcmux = {1'b0, br};
                push(1'b0, o);
            end
            7'h6f: begin
                o.rfmux = 4; o.ld_rf = 1; o.amux1 = 1; o.amux2 = 4; o.pcmux = 1; o.ld_pc = 1;
                push(1'b0, o);
            end
            7'h67: begin o.rfmux = 4; o.ld_rf = 1; o.pcmux = 2; o.ld_pc = 1; push(1'b0, o); end
            7'h03: begin
                o.mmux = 1; o.ld_mar = 1; push(1'b0, o);
                for (int i = 0; i < md; i++) begin
                    o = base(); o.rd = 1; o.ld_mdr = (i == md - 1); push(i == md - 1, o);
                end
                o = base(); o.rfmux = 3; o.ld_rf = 1; o.ld_pc = 1; push(1'b0, o);
                stall_add += md - 1;
            end
            default: begin
                o.amux2 = 3; o.mmux = 1; o.ld_mar = 1; o.ld_dout = 1; push(1'b0, o);
                case (f3)
                    3'd0:    mask = 4'b0001 << lo;
                    3'd1:    mask = 4'b0011 << {lo[1], 1'b0};
                    default: mask = 4'hF;
                endcase
                for (int i = 0; i < md; i++) begin
                    o = base(); o.wr = 1; o.mbe = mask; push(i == md - 1, o);
                end
                o = base(); o.ld_pc = 1; push(1'b0, o);
                stall_add += md - 1;
            end
        endcase
    endfunction

    // Plays one instruction; stop_after >= 0 truncates the schedule (for reset tests).
    task automatic run(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic br, input logic [1:0] lo,
                       input int fd, input int md, input int stop_after, input logic late);
        int n;
        opcode = opc; funct3 = f3; funct7 = f7; br_en = br; mar_lo = lo;
        trace.delete();
        seen.delete();
        build(opc, f3, f7, br, lo, fd, md);
        last_len = trace.size();
        n = (stop_after < 0) ? last_len : stop_after;
        for (int i = 0; i < n; i++) begin
            mem_resp = trace[i].resp | (late && i == 0);
            #1;
            if (i == 0) begin
                check({tag, " instr_retired"}, 64'(instr_retired), 64'(PERF ? exp_ret : 0));
                check({tag, " stall_cycles"}, 64'(stall_cycles), 64'(PERF ? exp_stall : 0));
            end
            check($sformatf("%s cyc%0d", tag, i), 64'(cur()), 64'(trace[i].o));
            seen.push_back(cur());
            @(negedge clk);
        end
        if (stop_after < 0) begin
            exp_ret++;
            exp_stall += stall_add;
        end
        $display("txn %-10s opcode=%02h f3=%0d cycles=%0d", tag, opc, f3, n);
    endtask

    initial begin
        int wr_cnt;
        int ill_cnt;
        logic [31:0] s0;
        rst = 1'b1; opcode = 7'h13; funct3 = 0; funct7 = 0; br_en = 0; mar_lo = 0; mem_resp = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset outs", 64'(cur()), 64'(base()));
        check("reset mbe", 64'(mem_byte_enable), 64'(4'b1111));
        check("reset instr_retired", 64'(instr_retired), 64'(0));
        rst = 1'b0;

        run("addi", 7'h13, 3'd0, 7'h00, 0, 0, 1, 1, -1, 0);
        check("addi len", 64'(last_len), 64'(5));
        check("addi load_regfile", 64'(seen[4].ld_rf), 64'(1));
        #1 check("addi retired", 64'(instr_retired), 64'(PERF ? 1 : 0));

        run("sub", 7'h33, 3'd0, 7'h20, 0, 0, 1, 1, -1, 0);
        check("sub aluop", 64'(seen[4].alu), 64'(3));
        run("sra", 7'h33, 3'd5, 7'h20, 0, 0, 1, 1, -1, 0);
        check("sra aluop", 64'(seen[4].alu), 64'(2));
        run("slti", 7'h13, 3'd2, 7'h00, 0, 0, 1, 1, -1, 0);
        run("sltu", 7'h33, 3'd3, 7'h00, 0, 0, 1, 1, -1, 0);
        run("srai", 7'h13, 3'd5, 7'h20, 0, 0, 2, 1, -1, 0);
        run("srli", 7'h13, 3'd5, 7'h00, 0, 0, 1, 1, -1, 0);
        run("andi", 7'h13, 3'd7, 7'h20, 0, 0, 1, 1, -1, 0);
        run("lui", 7'h37, 3'd0, 7'h00, 0, 0, 1, 1, -1, 0);
        run("auipc", 7'h17, 3'd0, 7'h00, 0, 0, 1, 1, -1, 0);
        run("jal", 7'h6f, 3'd0, 7'h00, 0, 0, 1, 1, -1, 0);
        run("jalr", 7'h67, 3'd0, 7'h00, 0, 0, 1, 1, -1, 0);

        run("beq_nt", 7'h63, 3'd0, 7'h00, 0, 0, 1, 1, -1, 0);
        check("beq_nt pcmux", 64'(seen[4].pcmux), 64'(0));
        check("beq_nt load_regfile", 64'(seen[4].ld_rf), 64'(0));
        run("beq_t", 7'h63, 3'd0, 7'h00, 1, 0, 1, 1, -1, 0);
        check("beq_t pcmux", 64'(seen[4].pcmux), 64'(1));
        run("bltu_t", 7'h63, 3'd6, 7'h00, 1, 0, 1, 1, -1, 0);

        run("lw", 7'h03, 3'd2, 7'h00, 0, 0, 1, 1, -1, 0);
        check("lw len", 64'(last_len), 64'(7));
        run("lh", 7'h03, 3'd1, 7'h00, 0, 0, 2, 2, -1, 0);

        s0 = stall_cycles;
        run("sb", 7'h23, 3'd0, 7'h00, 0, 2'd2, 1, 3, -1, 0);
        wr_cnt = 0;
        foreach (seen[i]) if (seen[i].wr) wr_cnt++;
        check("sb len", 64'(last_len), 64'(9));
        check("sb mem_write cycles", 64'(wr_cnt), 64'(3));
        check("sb mbe", 64'(seen[5].mbe), 64'(4'b0100));
        #1 check("sb stall delta", 64'(stall_cycles - s0), 64'(PERF ? 2 : 0));
        run("sh", 7'h23, 3'd1, 7'h00, 0, 2'd3, 1, 1, -1, 0);
        check("sh mbe", 64'(seen[5].mbe), 64'(4'b1100));
        run("sw", 7'h23, 3'd2, 7'h00, 0, 2'd1, 1, 1, -1, 0);
        run("sb_lo1", 7'h23, 3'd0, 7'h00, 0, 2'd1, 3, 2, -1, 0);

        run("illegal", 7'h7f, 3'd0, 7'h00, 0, 0, 1, 1, -1, 0);
        ill_cnt = 0;
        foreach (seen[i]) if (seen[i].ill) ill_cnt++;
        check("illegal len", 64'(last_len), 64'(4));
        check("illegal pulses", 64'(ill_cnt), 64'(1));
        check("illegal in decode", 64'(seen[3].ill), 64'(1));

        run("lw_rst", 7'h03, 3'd2, 7'h00, 0, 0, 1, 5, 7, 0);
        check("pre-reset mem_read", 64'(seen[6].rd), 64'(1));
        mem_resp = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid-wait reset mem_read", 64'(mem_read), 64'(0));
        check("mid-wait reset outs", 64'(cur()), 64'(base()));
        exp_ret = 0;
        exp_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        run("addi_late", 7'h13, 3'd4, 7'h00, 0, 0, 2, 1, -1, 1);

        #1;
        check("final instr_retired", 64'(instr_retired), 64'(PERF ? exp_ret : 0));
        check("final stall_cycles", 64'(stall_cycles), 64'(PERF ? exp_stall : 0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
